// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the MEM-stage data memory.
//   - SZ_BYTE / SZ_HALF / SZ_WORD : access size encodings (2'b11 behaves as word)
//   - LAT_MIN / LAT_MAX           : legal bounds of the access latency parameter
//   - dmemState_t                 : controller state encoding
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // waiting for a request
      WAIT = 2'd1,   // counting down the access latency
      RESP = 2'd2    // completion cycle (done high)
   } dmemState_t;

endpackage

// File: rtl/dmem_extract.sv
// dmem_extract: combinational load lane select and extension.
//   lane0..lane3 : bytes at A, A+1, A+2, A+3 (big-endian: lane0 is the MSB)
//   size         : access size encoding
//   addrLo       : A[1:0], used for alignment
//   signExt      : 1 = sign-extend byte/half loads, 0 = zero-extend
//   loadData     : assembled 32-bit load value
//   misalign     : half with A[0]=1 or word with A[1:0]!=0
module dmem_extract
   import dmem_pkg::*;
(
   input  logic [7:0]  lane0,
   input  logic [7:0]  lane1,
   input  logic [7:0]  lane2,
   input  logic [7:0]  lane3,
   input  logic [1:0]  size,
   input  logic [1:0]  addrLo,
   input  logic        signExt,
   output logic [31:0] loadData,
   output logic        misalign
);

   always_comb begin
      loadData = '0;
      misalign = 1'b0;
      case (size)
         SZ_BYTE: begin
            loadData = {{24{signExt & lane0[7]}}, lane0};
         end
         SZ_HALF: begin
            misalign = addrLo[0];
            loadData = {{16{signExt & lane0[7]}}, lane0, lane1};
         end
         default: begin  // SZ_WORD and the reserved 2'b11
            misalign = |addrLo;
            loadData = {lane0, lane1, lane2, lane3};
         end
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed big-endian data memory for the MEM stage with
// a req/done handshake and a fixed access latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request, held until accepted (accepted in IDLE or RESP)
//   we         : 1 = store, 0 = load
//   size       : 00 byte, 01 half, 10/11 word
//   sign_ext   : load extension select
//   addr       : byte address, only the low ADDR_W bits are used
//   wdata      : right-aligned store data
//   rdata      : load result, held until the next load completes
//   done       : high for the completion cycle
//   busy       : high while the latency counter runs; requests are ignored
//   misalign   : qualifies done, access was misaligned and dropped
//
// Handshake: an access is accepted on a rising edge where req=1 and the
// controller is in IDLE or RESP. done rises LATENCY edges after acceptance
// (counting the accepting edge) and lasts one cycle unless another request
// is accepted in that same RESP cycle. Memory writes and rdata updates both
// happen on the edge that enters RESP.
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        busy,
   output logic        misalign
);

   localparam int DEPTH = 1 << ADDR_W;
   // Out-of-range latencies are clamped into the supported window.
   localparam int LAT_EFF = (LATENCY < LAT_MIN) ? LAT_MIN :
                            (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
   localparam logic [2:0] CNT_LOAD = 3'((LAT_EFF > 1) ? (LAT_EFF - 2) : 0);

   typedef logic [ADDR_W-1:0] addr_t;

   dmemState_t  state;
   logic [2:0]  cnt;

   // Access captured at acceptance
   logic        weQ;
   logic [1:0]  sizeQ;
   logic        signExtQ;
   addr_t       addrQ;
   logic [31:0] wdataQ;

   logic [31:0] rdataQ;
   logic        misQ;

   logic [7:0]  mem [DEPTH];

   logic        accept;
   logic        finish;

   // The access that completes at the coming edge
   logic        accWe;
   logic [1:0]  accSize;
   logic        accSx;
   addr_t       accAddr;
   logic [31:0] accWdata;
   addr_t       a0, a1, a2, a3;
   logic [31:0] loadVal;
   logic        accMis;

   logic        unusedAddrBits;
   assign unusedAddrBits = ^addr[31:ADDR_W];

   assign accept = req && ((state == IDLE) || (state == RESP));
   // With a single-cycle latency the accepting edge is also the completing edge.
   assign finish = ((state == WAIT) && (cnt == 3'd0)) || (accept && (LAT_EFF == 1));

   // In WAIT the access comes from the capture registers; otherwise it is
   // the one being accepted right now (only reaches finish when LATENCY=1).
   always_comb begin
      if (state == WAIT) begin
         accWe    = weQ;
         accSize  = sizeQ;
         accSx    = signExtQ;
         accAddr  = addrQ;
         accWdata = wdataQ;
      end else begin
         accWe    = we;
         accSize  = size;
         accSx    = sign_ext;
         accAddr  = addr[ADDR_W-1:0];
         accWdata = wdata;
      end
   end

   // Lane addresses wrap naturally in ADDR_W bits.
   assign a0 = accAddr;
   assign a1 = accAddr + addr_t'(1);
   assign a2 = accAddr + addr_t'(2);
   assign a3 = accAddr + addr_t'(3);

   dmem_extract u_extract (
      .lane0    (mem[a0]),
      .lane1    (mem[a1]),
      .lane2    (mem[a2]),
      .lane3    (mem[a3]),
      .size     (accSize),
      .addrLo   (accAddr[1:0]),
      .signExt  (accSx),
      .loadData (loadVal),
      .misalign (accMis)
   );

   // Memory array shares the reset block so a store is never committed while
   // rst_n is low; the array itself is deliberately left unreset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 3'd0;
         weQ      <= 1'b0;
         sizeQ    <= SZ_BYTE;
         signExtQ <= 1'b0;
         addrQ    <= '0;
         wdataQ   <= '0;
         rdataQ   <= '0;
         misQ     <= 1'b0;
      end else begin
         if (accept) begin
            weQ      <= we;
            sizeQ    <= size;
            signExtQ <= sign_ext;
            addrQ    <= addr[ADDR_W-1:0];
            wdataQ   <= wdata;
            if (LAT_EFF == 1) begin
               state <= RESP;
            end else begin
               state <= WAIT;
               cnt   <= CNT_LOAD;
            end
         end else begin
            case (state)
               WAIT: begin
                  if (cnt == 3'd0) state <= RESP;
                  else             cnt   <= cnt - 3'd1;
               end
               default: state <= IDLE;
            endcase
         end

         // misalign is only meaningful alongside done, so it drops otherwise.
         misQ <= 1'b0;
         if (finish) begin
            misQ <= accMis;
            if (accMis) begin
               rdataQ <= '0;
            end else if (!accWe) begin
               rdataQ <= loadVal;
            end else begin
               case (accSize)
                  SZ_BYTE: begin
                     mem[a0] <= accWdata[7:0];
                  end
                  SZ_HALF: begin
                     mem[a0] <= accWdata[15:8];
                     mem[a1] <= accWdata[7:0];
                  end
                  default: begin
                     mem[a0] <= accWdata[31:24];
                     mem[a1] <= accWdata[23:16];
                     mem[a2] <= accWdata[15:8];
                     mem[a3] <= accWdata[7:0];
                  end
               endcase
            end
         end
      end
   end

   assign done     = (state == RESP);
   assign busy     = (state == WAIT);
   assign misalign = misQ;
   assign rdata    = rdataQ;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed bench with two controllers, LATENCY=1 (dut1)
// and LATENCY=4 (dut4), sharing one clock with independent resets.
module tb_data_mem_ctrl;
   import dmem_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, req1, we1, sx1;
   logic [1:0]  size1;
   logic [31:0] addr1, wdata1, rdata1;
   logic        done1, busy1, mis1;

   logic        rst4, req4, we4, sx4;
   logic [1:0]  size4;
   logic [31:0] addr4, wdata4, rdata4;
   logic        done4, busy4, mis4;

   int nTests = 0;
   int nFail  = 0;

   data_mem_ctrl #(.ADDR_W(8), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst1), .req(req1), .we(we1), .size(size1),
      .sign_ext(sx1), .addr(addr1), .wdata(wdata1), .rdata(rdata1),
      .done(done1), .busy(busy1), .misalign(mis1)
   );

   data_mem_ctrl #(.ADDR_W(8), .LATENCY(4)) dut4 (
      .clk(clk), .rst_n(rst4), .req(req4), .we(we4), .size(size4),
      .sign_ext(sx4), .addr(addr4), .wdata(wdata4), .rdata(rdata4),
      .done(done4), .busy(busy4), .misalign(mis4)
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One LATENCY=1 access: drive on the falling edge, completion is visible
   // just after the next rising edge. req stays high so consecutive calls
   // are back-to-back.
   task automatic acc1(input string tag, input logic w, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic expMis, input logic [31:0] expRd);
      @(negedge clk);
      req1 = 1'b1; we1 = w; size1 = sz; sx1 = sx; addr1 = a; wdata1 = wd;
      @(posedge clk); #1;
      check({tag, "_done"},  32'(done1), 32'd1);
      check({tag, "_mis"},   32'(mis1),  32'(expMis));
      check({tag, "_rdata"}, rdata1,     expRd);
   endtask

   // One LATENCY=4 cycle: observe outputs just after the rising edge.
   task automatic step4(input string tag, input logic eBusy, input logic eDone,
                        input logic eMis, input logic [31:0] eRd);
      @(posedge clk); #1;
      check({tag, "_busy"},  32'(busy4), 32'(eBusy));
      check({tag, "_done"},  32'(done4), 32'(eDone));
      check({tag, "_mis"},   32'(mis4),  32'(eMis));
      check({tag, "_rdata"}, rdata4,     eRd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst1 = 1'b0; rst4 = 1'b0;
      // dut1 holds a store request through reset; it must not be accepted.
      req1 = 1'b1; we1 = 1'b1; size1 = SZ_WORD; sx1 = 1'b0;
      addr1 = 32'h10; wdata1 = 32'hDEADBEEF;
      req4 = 1'b0; we4 = 1'b0; size4 = SZ_WORD; sx4 = 1'b0;
      addr4 = 32'h0; wdata4 = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_done1",  32'(done1), 32'd0);
      check("rst_busy1",  32'(busy1), 32'd0);
      check("rst_mis1",   32'(mis1),  32'd0);
      check("rst_rdata1", rdata1,     32'd0);
      check("rst_done4",  32'(done4), 32'd0);
      check("rst_busy4",  32'(busy4), 32'd0);

      @(negedge clk);
      rst1 = 1'b1; rst4 = 1'b1;
      // First edge after release accepts the pending sw; L=1 -> done now.
      @(posedge clk); #1;
      check("first_done",  32'(done1), 32'd1);
      check("first_mis",   32'(mis1),  32'd0);
      check("first_rdata", rdata1,     32'd0);

      // Back-to-back LATENCY=1 traffic
      acc1("lw10",    1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0, 1'b0, 32'hDEADBEEF);
      acc1("lbu10",   1'b0, SZ_BYTE, 1'b0, 32'h10,  32'h0, 1'b0, 32'h000000DE);
      acc1("lbu11",   1'b0, SZ_BYTE, 1'b0, 32'h11,  32'h0, 1'b0, 32'h000000AD);
      acc1("lbu12",   1'b0, SZ_BYTE, 1'b0, 32'h12,  32'h0, 1'b0, 32'h000000BE);
      acc1("lbu13",   1'b0, SZ_BYTE, 1'b0, 32'h13,  32'h0, 1'b0, 32'h000000EF);
      acc1("lb13",    1'b0, SZ_BYTE, 1'b1, 32'h13,  32'h0, 1'b0, 32'hFFFFFFEF);
      acc1("lb10",    1'b0, SZ_BYTE, 1'b1, 32'h10,  32'h0, 1'b0, 32'hFFFFFFDE);
      acc1("lh12",    1'b0, SZ_HALF, 1'b1, 32'h12,  32'h0, 1'b0, 32'hFFFFBEEF);
      acc1("lhu10",   1'b0, SZ_HALF, 1'b0, 32'h10,  32'h0, 1'b0, 32'h0000DEAD);
      acc1("sh10",    1'b1, SZ_HALF, 1'b0, 32'h10,  32'hFFFF1234, 1'b0, 32'h0000DEAD);
      acc1("lw10b",   1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0, 1'b0, 32'h1234BEEF);
      acc1("lw11mis", 1'b0, SZ_WORD, 1'b0, 32'h11,  32'h0, 1'b1, 32'h0);
      acc1("sh13mis", 1'b1, SZ_HALF, 1'b0, 32'h13,  32'h0000AAAA, 1'b1, 32'h0);
      acc1("lw10c",   1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0, 1'b0, 32'h1234BEEF);
      acc1("lsz3",    1'b0, 2'b11,   1'b0, 32'h10,  32'h0, 1'b0, 32'h1234BEEF);
      acc1("sb11",    1'b1, SZ_BYTE, 1'b0, 32'h11,  32'hAAAAAA77, 1'b0, 32'h1234BEEF);
      acc1("lw10d",   1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0, 1'b0, 32'h1277BEEF);
      acc1("swFC",    1'b1, SZ_WORD, 1'b0, 32'hFC,  32'hCAFEF00D, 1'b0, 32'h1277BEEF);
      acc1("swFEmis", 1'b1, SZ_WORD, 1'b0, 32'hFE,  32'h5555AAAA, 1'b1, 32'h0);
      acc1("lw1FC",   1'b0, SZ_WORD, 1'b0, 32'h1FC, 32'h0, 1'b0, 32'hCAFEF00D);
      acc1("lbFF",    1'b0, SZ_BYTE, 1'b1, 32'hFF,  32'h0, 1'b0, 32'h0000000D);
      acc1("lh1FE",   1'b0, SZ_HALF, 1'b1, 32'h1FE, 32'h0, 1'b0, 32'hFFFFF00D);

      @(negedge clk);
      req1 = 1'b0;
      @(posedge clk); #1;
      check("idle_done1",  32'(done1), 32'd0);
      check("idle_busy1",  32'(busy1), 32'd0);
      check("idle_rdata1", rdata1,     32'hFFFFF00D);

      // LATENCY=4: store, then a load presented while busy (must wait for RESP)
      @(negedge clk);
      req4 = 1'b1; we4 = 1'b1; size4 = SZ_WORD; addr4 = 32'h20; wdata4 = 32'h11223344;
      step4("l4_s1", 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      we4 = 1'b0;
      step4("l4_s2", 1'b1, 1'b0, 1'b0, 32'h0);
      step4("l4_s3", 1'b1, 1'b0, 1'b0, 32'h0);
      step4("l4_sd", 1'b0, 1'b1, 1'b0, 32'h0);
      step4("l4_l1", 1'b1, 1'b0, 1'b0, 32'h0);
      step4("l4_l2", 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      req4 = 1'b0;
      step4("l4_l3", 1'b1, 1'b0, 1'b0, 32'h0);
      step4("l4_ld", 1'b0, 1'b1, 1'b0, 32'h11223344);
      step4("l4_idle", 1'b0, 1'b0, 1'b0, 32'h11223344);

      // Reset in the middle of a store's WAIT phase
      @(negedge clk);
      req4 = 1'b1; we4 = 1'b1; addr4 = 32'h20; wdata4 = 32'h99999999;
      step4("rw_s1", 1'b1, 1'b0, 1'b0, 32'h11223344);
      @(negedge clk);
      req4 = 1'b0;
      #2 rst4 = 1'b0;
      #1;
      check("rw_busy",  32'(busy4), 32'd0);
      check("rw_done",  32'(done4), 32'd0);
      check("rw_mis",   32'(mis4),  32'd0);
      check("rw_rdata", rdata4,     32'd0);
      @(negedge clk);
      rst4 = 1'b1;
      @(negedge clk);
      req4 = 1'b1; we4 = 1'b0; addr4 = 32'h20;
      step4("rw_l1", 1'b1, 1'b0, 1'b0, 32'h0);
      step4("rw_l2", 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      req4 = 1'b0;
      step4("rw_l3", 1'b1, 1'b0, 1'b0, 32'h0);
      step4("rw_ld", 1'b0, 1'b1, 1'b0, 32'h11223344);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised byte-addressed data memory for the MEM stage of the pipelined MIPS core. Supports byte, halfword and word loads/stores with big-endian byte order, sign or zero extension, and misalignment detection. A req/done handshake with configurable access latency lets the pipeline stall on slow memory. The block replaces the fixed word-only data memory and is driven by the EX/MEM register.

## Interface
Parameters:
- ADDR_W, 8: byte-address bits used; depth is 2^ADDR_W bytes.
- LATENCY, 1: cycles from acceptance to done; legal range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request; held by the requester until accepted.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- sign_ext  in  1  load extension: 1 = sign, 0 = zero.
- addr  in  32  byte address; bits above ADDR_W are ignored (wraps modulo depth).
- wdata  in  32  store data, right-aligned for byte and half.
- rdata  out  32  load result; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.
- busy  out  1  access in flight, new req not accepted; reset 0.
- misalign  out  1  qualifies done: the access was misaligned and dropped; reset 0.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: counting down the access latency.
  - RESP: completion cycle.
- Acceptance: req=1 at a rising edge while in IDLE or RESP. At acceptance, register we, size, sign_ext, addr[ADDR_W-1:0] and wdata.
- Transition on acceptance: to RESP if LATENCY=1; otherwise to WAIT with the counter loaded to LATENCY-2.
- WAIT: decrement the counter each cycle; when it reaches 0, go to RESP.
- RESP: done=1. With req=1, accept a new access (back-to-back); otherwise go to IDLE.
- busy=1 only in WAIT. A req during WAIT is ignored and not queued.
- Byte lanes, big-endian, for access address A:
  - word: ram[A]=wdata[31:24], ram[A+1]=[23:16], ram[A+2]=[15:8], ram[A+3]=[7:0].
  - half: ram[A]=wdata[15:8], ram[A+1]=wdata[7:0].
  - byte: ram[A]=wdata[7:0].
  - Loads assemble the same lanes and extend to 32 bits per sign_ext.
- Address arithmetic A+k wraps modulo 2^ADDR_W.
- Misaligned access: half with A[0]=1, or word with A[1:0]≠0.
  - Memory is not touched.
  - The handshake completes normally with misalign=1 and rdata=0.
- Stores: commit on the edge entering RESP. In RESP, rdata holds its previous value.
- Loads: rdata is updated on the edge entering RESP and held until the next load completes.
- Memory contents are not reset and are X until written.

## Timing
- Request accepted at edge k: done=1 during cycle k+LATENCY, exactly one cycle unless back-to-back.
- With LATENCY=1, sustained throughput is one access per cycle.
- A load immediately following a store to the same address returns the new data.
- rst_n low at any time, including mid-access: the following take effect immediately, asynchronously:
  - state goes to IDLE;
  - done, busy, misalign and rdata go to 0;
  - any store that has not yet reached RESP is dropped.
- First acceptance after reset is at the first rising edge with rst_n=1 and req=1.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum IDLE/WAIT/RESP;
  - the LATENCY range check constants.
- Sub-module dmem_extract: combinational lane select plus sign/zero extension from the four addressed bytes, size, A[1:0] and sign_ext.
- Counter width is 3 bits.

## Test plan
- Reset: hold rst_n=0 with req=1 -> done=busy=misalign=0 and rdata=0. Release -> first access is accepted at the next edge.
- LATENCY=1, sw 0xDEADBEEF @0x10 then lw @0x10 back-to-back -> done on two consecutive cycles, rdata=0xDEADBEEF. Bytes are 0xDE,0xAD,0xBE,0xEF at 0x10..0x13.
- lb @0x13 signed -> 0xFFFFFFEF. lbu @0x13 -> 0x000000EF. lh @0x12 signed -> 0xFFFFBEEF. sh 0x1234 @0x10 then lw @0x10 -> 0x1234BEEF.
- Misaligned lw @0x11 and sh @0x13 -> done with misalign=1 and rdata=0. Memory unchanged, verified by lw @0x10.
- LATENCY=4: req held high -> busy in cycles k+1..k+3, done in k+4. req during busy is not accepted. Wrap test: ADDR_W=8, sw @0xFE -> bytes land at 0xFE, 0xFF, 0x00, 0x01 (reported misaligned, so no write) while sw @0xFC lands at 0xFC..0xFF.
- Reset asserted during WAIT of a store (LATENCY=4) -> outputs go to 0 immediately. A later lw of that address returns the old contents.
